// File: rtl/intersection_sequencer.sv
// intersection_sequencer
// ----------------------
// Central phase controller for a two-direction traffic intersection.
// Walks the two signal heads through all-red, green and yellow phases,
// paced by a 1 Hz tick. A green phase is extended while only its own
// direction has demand. An emergency level forces both heads to red.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   tick     : one-cycle 1 Hz enable pulse
//   req0     : demand level, direction 0
//   req1     : demand level, direction 1
//   emg      : emergency override level
//   light0   : direction 0 lamps {R,Y,G}, one-hot
//   light1   : direction 1 lamps {R,Y,G}, one-hot
//   count0   : direction 0 ticks left in its green/yellow phase, else 0
//   count1   : direction 1 ticks left in its green/yellow phase, else 0
//   pattern0 : 1 = walk figure for direction 0 (direction 1 green)
//   pattern1 : 1 = walk figure for direction 1 (direction 0 green)
//   phase    : current state code (debug / verification)
//
// There are no valid/ready handshakes here: every output is a registered
// level that is valid on every cycle after reset.

module intersection_sequencer #(
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req0,
    input  logic       req1,
    input  logic       emg,
    output logic [2:0] light0,
    output logic [2:0] light1,
    output logic [2:0] count0,
    output logic [2:0] count1,
    output logic       pattern0,
    output logic       pattern1,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        AR_A = 3'd0,
        G0   = 3'd1,
        Y0   = 3'd2,
        AR_B = 3'd3,
        G1   = 3'd4,
        Y1   = 3'd5,
        EMG  = 3'd6
    } state_t;

    localparam logic [2:0] GREEN_L  = 3'(GREEN_T);
    localparam logic [2:0] YELLOW_L = 3'(YELLOW_T);
    localparam logic [2:0] ALLRED_L = 3'(ALLRED_T);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t     state, state_n;
    logic [2:0] timer, timer_n;

    logic [2:0] light0_n, light1_n, count0_n, count1_n;
    logic       pattern0_n, pattern1_n;

    // Next state and timer. Emergency has priority over any tick or phase
    // end; a phase ends on the tick that finds the timer at 1.
    always_comb begin
        state_n = state;
        timer_n = timer;
        if (emg) begin
            state_n = EMG;
            timer_n = 3'd0;
        end else if (state == EMG) begin
            state_n = AR_A;
            timer_n = ALLRED_L;
        end else if (tick) begin
            if (timer == 3'd1) begin
                unique case (state)
                    AR_A: begin state_n = G0; timer_n = GREEN_L; end
                    G0: begin
                        // Hold green only while the other direction is idle.
                        if (req0 && !req1) begin
                            state_n = G0;
                            timer_n = GREEN_L;
                        end else begin
                            state_n = Y0;
                            timer_n = YELLOW_L;
                        end
                    end
                    Y0:   begin state_n = AR_B; timer_n = ALLRED_L; end
                    AR_B: begin state_n = G1;   timer_n = GREEN_L;  end
                    G1: begin
                        if (req1 && !req0) begin
                            state_n = G1;
                            timer_n = GREEN_L;
                        end else begin
                            state_n = Y1;
                            timer_n = YELLOW_L;
                        end
                    end
                    Y1:      begin state_n = AR_A; timer_n = ALLRED_L; end
                    default: begin state_n = AR_A; timer_n = ALLRED_L; end
                endcase
            end else begin
                timer_n = timer - 3'd1;
            end
        end
    end

    // Output decode from the next state/timer so the registered outputs
    // line up with the state register on the same cycle.
    always_comb begin
        light0_n   = LAMP_R;
        light1_n   = LAMP_R;
        count0_n   = 3'd0;
        count1_n   = 3'd0;
        pattern0_n = 1'b0;
        pattern1_n = 1'b0;
        unique case (state_n)
            G0: begin
                light0_n   = LAMP_G;
                count0_n   = timer_n;
                pattern1_n = 1'b1;
            end
            Y0: begin
                light0_n = LAMP_Y;
                count0_n = timer_n;
            end
            G1: begin
                light1_n   = LAMP_G;
                count1_n   = timer_n;
                pattern0_n = 1'b1;
            end
            Y1: begin
                light1_n = LAMP_Y;
                count1_n = timer_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= AR_A;
            timer    <= ALLRED_L;
            light0   <= LAMP_R;
            light1   <= LAMP_R;
            count0   <= 3'd0;
            count1   <= 3'd0;
            pattern0 <= 1'b0;
            pattern1 <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            light0   <= light0_n;
            light1   <= light1_n;
            count0   <= count0_n;
            count1   <= count1_n;
            pattern0 <= pattern0_n;
            pattern1 <= pattern1_n;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Testbench for intersection_sequencer (GREEN_T=5, YELLOW_T=2, ALLRED_T=1).
// Directed stimulus pushes hand-computed expected output vectors into a
// queue; a monitor pops and compares them on the falling clock edge.

module tb_intersection_sequencer;

    localparam int W = 17; // {phase, light0, light1, count0, count1, pattern0, pattern1}

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       emg = 1'b0;
    logic [2:0] light0, light1, count0, count1, phase;
    logic       pattern0, pattern1;

    intersection_sequencer #(
        .GREEN_T(5),
        .YELLOW_T(2),
        .ALLRED_T(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .req0(req0),
        .req1(req1),
        .emg(emg),
        .light0(light0),
        .light1(light1),
        .count0(count0),
        .count1(count1),
        .pattern0(pattern0),
        .pattern1(pattern1),
        .phase(phase)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // Build an expected vector from phase code and counts using the lamp
    // and walk-figure table of each phase.
    function automatic logic [W-1:0] mk_exp(input logic [2:0] ph,
                                            input logic [2:0] c0,
                                            input logic [2:0] c1);
        logic [2:0] l0, l1;
        logic       p0, p1;
        l0 = 3'b100; l1 = 3'b100; p0 = 1'b0; p1 = 1'b0;
        case (ph)
            3'd1: begin l0 = 3'b001; p1 = 1'b1; end
            3'd2: l0 = 3'b010;
            3'd4: begin l1 = 3'b001; p0 = 1'b1; end
            3'd5: l1 = 3'b010;
            default: ;
        endcase
        return {ph, l0, l1, c0, c1, p0, p1};
    endfunction

    // Driver tasks: each step drives inputs for one clock edge and returns
    // just after that edge.
    task automatic step(input logic t, input logic r0, input logic r1, input logic e);
        tick = t; req0 = r0; req1 = r1; emg = e;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // One tick period: three idle clocks, then a tick clock.
    task automatic tp(input logic r0, input logic r1);
        repeat (3) step(1'b0, r0, r1, 1'b0);
        step(1'b1, r0, r1, 1'b0);
    endtask

    task automatic expect_now(input logic [2:0] ph, input logic [2:0] c0,
                              input logic [2:0] c1, input string nm);
        exp_q.push_back(mk_exp(ph, c0, c1));
        name_q.push_back(nm);
    endtask

    // Monitor: compare outputs against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [W-1:0] e, got;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {phase, light0, light1, count0, count1, pattern0, pattern1};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL %s: got ph=%0d l0=%b l1=%b c0=%0d c1=%0d p0=%b p1=%b, expected ph=%0d l0=%b l1=%b c0=%0d c1=%0d p0=%b p1=%b",
                              nm, got[16:14], got[13:11], got[10:8], got[7:5], got[4:2], got[1], got[0],
                              e[16:14], e[13:11], e[10:8], e[7:5], e[4:2], e[1], e[0]);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_now(3'd0, 3'd0, 3'd0, "reset");

        // Full cycle, no demand
        tp(0, 0); expect_now(3'd1, 3'd5, 3'd0, "g0_enter");
        for (int c = 4; c >= 1; c--) begin
            tp(0, 0); expect_now(3'd1, 3'(c), 3'd0, "g0_count");
        end
        tp(0, 0); expect_now(3'd2, 3'd2, 3'd0, "y0_enter");
        tp(0, 0); expect_now(3'd2, 3'd1, 3'd0, "y0_count");
        tp(0, 0); expect_now(3'd3, 3'd0, 3'd0, "arb_enter");
        tp(0, 0); expect_now(3'd4, 3'd0, 3'd5, "g1_enter");
        for (int c = 4; c >= 1; c--) begin
            tp(0, 0); expect_now(3'd4, 3'd0, 3'(c), "g1_count");
        end
        tp(0, 0); expect_now(3'd5, 3'd0, 3'd2, "y1_enter");
        tp(0, 0); expect_now(3'd5, 3'd0, 3'd1, "y1_count");
        tp(0, 0); expect_now(3'd0, 3'd0, 3'd0, "ara_wrap");

        // Green hold on direction 0 demand
        tp(1, 0); expect_now(3'd1, 3'd5, 3'd0, "hold_g0_enter");
        repeat (4) tp(1, 0);
        expect_now(3'd1, 3'd1, 3'd0, "hold_g0_last");
        tp(1, 0); expect_now(3'd1, 3'd5, 3'd0, "hold_reload1");
        repeat (4) tp(1, 0);
        tp(1, 0); expect_now(3'd1, 3'd5, 3'd0, "hold_reload2");
        repeat (4) tp(1, 1);
        expect_now(3'd1, 3'd1, 3'd0, "hold_both_last");
        tp(1, 1); expect_now(3'd2, 3'd2, 3'd0, "hold_release_y0");
        tp(0, 0); expect_now(3'd2, 3'd1, 3'd0, "rel_y0_count");
        tp(0, 0); expect_now(3'd3, 3'd0, 3'd0, "rel_arb");
        tp(0, 0); expect_now(3'd4, 3'd0, 3'd5, "rel_g1");
        tp(0, 0);
        tp(0, 0); expect_now(3'd4, 3'd0, 3'd3, "g1_timer3");

        // Emergency mid-G1, no tick
        step(0, 0, 0, 1); expect_now(3'd6, 3'd0, 3'd0, "emg_enter");
        step(0, 0, 0, 1); expect_now(3'd6, 3'd0, 3'd0, "emg_hold2");
        step(0, 0, 0, 1); expect_now(3'd6, 3'd0, 3'd0, "emg_hold3");
        step(0, 0, 0, 0); expect_now(3'd0, 3'd0, 3'd0, "emg_exit_ara");
        tp(0, 0); expect_now(3'd1, 3'd5, 3'd0, "emg_exit_g0");

        // Tick gap in G0 with timer = 3
        tp(0, 0);
        tp(0, 0); expect_now(3'd1, 3'd3, 3'd0, "gap_start");
        repeat (10) step(0, 0, 0, 0);
        expect_now(3'd1, 3'd3, 3'd0, "gap_mid");
        repeat (10) step(0, 0, 0, 0);
        expect_now(3'd1, 3'd3, 3'd0, "gap_end");
        tp(0, 0); expect_now(3'd1, 3'd2, 3'd0, "gap_resume");
        tp(0, 0);
        tp(0, 0); expect_now(3'd2, 3'd2, 3'd0, "gap_y0");
        tp(0, 0); expect_now(3'd2, 3'd1, 3'd0, "y0_timer1");

        // Tick and emg together at Y0 phase end
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 1); expect_now(3'd6, 3'd0, 3'd0, "emg_beats_tick");
        step(0, 0, 0, 0); expect_now(3'd0, 3'd0, 3'd0, "emg2_exit");

        // Run to Y1
        repeat (13) tp(0, 0);
        expect_now(3'd4, 3'd0, 3'd1, "to_g1_last");
        tp(0, 0); expect_now(3'd5, 3'd0, 3'd2, "to_y1");

        // Reset in Y1
        rst = 1'b1;
        step(0, 0, 0, 0); expect_now(3'd0, 3'd0, 3'd0, "rst_in_y1");
        rst = 1'b0;
        tp(0, 0); expect_now(3'd1, 3'd5, 3'd0, "post_rst_g0");
        tp(0, 0); expect_now(3'd1, 3'd4, 3'd0, "post_rst_count");

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intersection_sequencer.md
Name: intersection_sequencer

Overview:
- Central phase controller for the two-direction traffic intersection.
- Sequences light 0 and light 1 through green, yellow and all-red phases from a 1 Hz tick.
- Drives per-direction countdown values for the seven-segment decoders and walk-pattern selects for the LED matrix drivers.
- Adds demand-based green hold and an emergency all-red override.

Parameters:
- GREEN_T, 5, green phase length in ticks (legal 1..7)
- YELLOW_T, 2, yellow phase length in ticks (legal 1..7)
- ALLRED_T, 1, all-red clearance length in ticks (legal 1..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle enable pulse at 1 Hz from the frequency divider
- req0  in  1  demand level for direction 0 (vehicle or pedestrian waiting)
- req1  in  1  demand level for direction 1
- emg  in  1  emergency override level
- light0  out  3  direction 0 lamps {R,Y,G}, one-hot
- light1  out  3  direction 1 lamps {R,Y,G}, one-hot
- count0  out  3  direction 0 remaining ticks in its green/yellow phase, else 0
- count1  out  3  direction 1 remaining ticks, same rule
- pattern0  out  1  1 = walk figure for direction 0 (direction 1 is green), else stop figure
- pattern1  out  1  1 = walk figure for direction 1 (direction 0 is green)
- phase  out  3  current state code, for debug and verification

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered and decoded from state and timer (Moore).
- Lamp encodings: red = 3'b100, yellow = 3'b010, green = 3'b001.
- States and codes, with what each drives:
  - AR_A = 0: both lamps red; leads to G0.
  - G0 = 1: light0 green, light1 red.
  - Y0 = 2: light0 yellow, light1 red.
  - AR_B = 3: both lamps red; leads to G1.
  - G1 = 4: light1 green, light0 red.
  - Y1 = 5: light1 yellow, light0 red.
  - EMG = 6: both lamps red; count0 = count1 = 0; pattern0 = pattern1 = 0.
- Timer:
  - A 3-bit down-counter is loaded with the phase length on entry to each phase.
  - It decrements only on cycles where tick=1.
  - The phase ends on the edge where tick=1 and timer==1, so each phase lasts exactly its length in ticks.
  - The timer never reaches 0 outside EMG.
- Normal transitions, all taken on the phase-end edge:
  - AR_A -> G0
  - G0 -> Y0
  - Y0 -> AR_B
  - AR_B -> G1
  - G1 -> Y1
  - Y1 -> AR_A
- Green hold:
  - At G0 phase end, if req1=0 and req0=1, stay in G0 and reload GREEN_T.
  - G1 behaves symmetrically (stays if req0=0 and req1=1).
  - If both requests are 0, advance normally; there is no rest-in-green.
- Emergency:
  - emg=1 forces the state to EMG on the next clock edge from any state, regardless of tick.
  - The timer is cleared to 0 while in EMG.
  - On the first edge with emg=0 while in EMG, go to AR_A with the timer loaded to ALLRED_T.
- Count outputs:
  - count0 = timer in G0 or Y0, else 0.
  - count1 = timer in G1 or Y1, else 0.
- Patterns: pattern0 = 1 only in G1; pattern1 = 1 only in G0.
- Simultaneous events:
  - emg beats tick and phase end.
  - rst beats everything.
  - req inputs are sampled only on the G-phase end edge.
- Reset value: state AR_A, timer = ALLRED_T, light0 = light1 = 3'b100, count0 = count1 = 0, pattern0 = pattern1 = 0, phase = 0.
- Reset mid-phase: returns to the reset values on the next edge; no partial phase is retained.

Test Plan:
- Reset, then a tick every 4 clocks, req0 = req1 = 0:
  - Phase sequence 0,1,2,3,4,5,0 with dwell of 1,5,2,1,5,2 ticks.
  - count0 shows 5,4,3,2,1 in G0, then 2,1 in Y0.
  - light0 = 001 in G0.
  - pattern1 = 1 throughout G0.
- req0 = 1, req1 = 0 held through G0: at each G0 phase end the state stays G0 and count0 reloads to 5. Then set req1 = 1: Y0 follows the next phase end.
- emg pulsed high for 3 clocks mid-G1 with timer = 3, no tick present:
  - phase = 6 on the next edge; lamps 100/100; counts 0.
  - After emg falls: phase = 0 with timer 1, then G0.
- tick and emg high in the same cycle as a Y0 phase end: state goes to EMG, not AR_B.
- rst asserted for one cycle in Y1: next edge phase = 0, lamps 100/100, counts 0; sequence resumes normally.
- Tick gap: tick held low for 20 clocks in G0 with timer = 3: state and count0 stay unchanged at 3.
